// File: rtl/add32f_seq_ctrl_pkg.sv
// Shared definitions for the add32f sequencer: FSM state encoding, FP32 field widths and
// constants, and the classification of a normalized result.
// No ports; imported by add32f_seq_ctrl and add32f_mant_alu.
`ifndef ADD32F_SEQ_CTRL_PKG_SV
`define ADD32F_SEQ_CTRL_PKG_SV
package add32f_seq_ctrl_pkg;

  // FP32 field widths
  localparam int unsigned ExpW  = 8;
  localparam int unsigned FracW = 23;
  localparam int unsigned SigW  = 24;  // fraction plus hidden bit

  // FP32 constants
  localparam int unsigned EXP_BIAS = 127;
  localparam int unsigned EXP_MAX  = 255;
  localparam logic [31:0] QNAN     = 32'h7FC0_0000;
  localparam logic [31:0] POS_INF  = 32'h7F80_0000;

  typedef enum logic [2:0] {
    StIdle   = 3'd0,
    StUnpack = 3'd1,
    StAlign  = 3'd2,
    StAdd    = 3'd3,
    StNorm   = 3'd4,
    StPack   = 3'd5,
    StDone   = 3'd6
  } state_e;

  // What PACK should assemble once normalization has finished.
  typedef enum logic [1:0] {
    KindNum  = 2'd0,
    KindZero = 2'd1,
    KindInf  = 2'd2
  } kind_e;

endpackage
`endif

// File: rtl/add32f_mant_alu.sv
// Combinational magnitude adder/subtractor for the float adder significands.
// Ports:
//   a_i, b_i : significands with guard bits (a_i >= b_i whenever sub_i is set)
//   sub_i    : 1 = a_i - b_i, 0 = a_i + b_i
//   sum_o    : low Width bits of the result
//   co_o     : carry out of the addition (always 0 on subtract)
module add32f_mant_alu #(
  parameter int unsigned Width = 27
) (
  input  logic [Width-1:0] a_i,
  input  logic [Width-1:0] b_i,
  input  logic             sub_i,
  output logic [Width-1:0] sum_o,
  output logic             co_o
);

  always_comb begin
    if (sub_i) begin
      {co_o, sum_o} = {1'b0, a_i} - {1'b0, b_i};
    end else begin
      {co_o, sum_o} = {1'b0, a_i} + {1'b0, b_i};
    end
  end

endmodule

// File: rtl/add32f_seq_ctrl.sv
// Multi-cycle IEEE754 single-precision adder sequencer. One operand pair at a time is taken
// over a valid/ready handshake, stepped through unpack/align/add/normalize/pack on a shared
// datapath (alignment and normalization one bit per cycle), and returned over valid/ready.
// Subnormal inputs are flushed to zero; rounding is toward zero.
// Ports:
//   clk_i, rst_i          : clock, synchronous active-high reset
//   in_valid_i/in_ready_o : operand handshake, a_i/b_i are the operands
//   out_valid_o/out_ready_i : result handshake, result_o with ovf_o/nan_o flags
//   busy_o                : high whenever the sequencer is not idle
module add32f_seq_ctrl
  import add32f_seq_ctrl_pkg::*;
#(
  parameter int unsigned AlignLimit = 25,
  parameter int unsigned GrdBits    = 3
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  input  logic [31:0] a_i,
  input  logic [31:0] b_i,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic [31:0] result_o,
  output logic        ovf_o,
  output logic        nan_o,
  output logic        busy_o
);

  localparam int unsigned MantW = SigW + GrdBits;  // hidden + fraction + guard
  localparam int unsigned SumW  = MantW + 1;       // plus carry
  localparam logic [ExpW-1:0] ExpOnes   = ExpW'(EXP_MAX);
  localparam logic [ExpW-1:0] AlignLimW = ExpW'(AlignLimit);

  state_e state_q, state_d;

  logic [31:0]       a_q, a_d, b_q, b_d;
  logic              sign_a_q, sign_a_d, sign_b_q, sign_b_d;
  logic [ExpW-1:0]   exp_q, exp_d, diff_q, diff_d;
  logic [MantW-1:0]  mant_a_q, mant_a_d, mant_b_q, mant_b_d;
  logic [SumW-1:0]   sum_q, sum_d;
  kind_e             kind_q, kind_d;
  logic [31:0]       res_q, res_d;
  logic              ovf_q, ovf_d, nan_q, nan_d;
  logic              norm_done;

  // Unpack decode, driven from the registered operands.
  logic [ExpW-1:0]  ea, eb, big_exp, small_exp, udiff;
  logic [FracW-1:0] fa, fb;
  logic [SigW-1:0]  sig_a, sig_b, big_sig, small_sig;
  logic             a_inf, a_nan, b_inf, b_nan, is_special, swap, big_sign, small_sign;
  logic [31:0]      special_res;
  logic             special_nan;

  always_comb begin
    ea         = a_q[30:23];
    eb         = b_q[30:23];
    fa         = a_q[22:0];
    fb         = b_q[22:0];
    a_inf      = (ea == ExpOnes) && (fa == '0);
    a_nan      = (ea == ExpOnes) && (fa != '0);
    b_inf      = (eb == ExpOnes) && (fb == '0);
    b_nan      = (eb == ExpOnes) && (fb != '0);
    is_special = (ea == ExpOnes) || (eb == ExpOnes);
    // exp==0 operands are flushed to a zero significand
    sig_a      = (ea == '0) ? '0 : {1'b1, fa};
    sig_b      = (eb == '0) ? '0 : {1'b1, fb};
    swap       = (eb > ea) || ((eb == ea) && (sig_b > sig_a));
    big_exp    = swap ? eb : ea;
    small_exp  = swap ? ea : eb;
    big_sig    = swap ? sig_b : sig_a;
    small_sig  = swap ? sig_a : sig_b;
    big_sign   = swap ? b_q[31] : a_q[31];
    small_sign = swap ? a_q[31] : b_q[31];
    udiff      = big_exp - small_exp;
    special_nan = a_nan || b_nan || (a_inf && b_inf && (a_q[31] != b_q[31]));
    if (special_nan) begin
      special_res = QNAN;
    end else begin
      special_res = POS_INF | {(a_inf ? a_q[31] : b_q[31]), 31'b0};
    end
  end

  logic [MantW-1:0] alu_sum;
  logic             alu_co;

  add32f_mant_alu #(
    .Width(MantW)
  ) u_mant_alu (
    .a_i  (mant_a_q),
    .b_i  (mant_b_q),
    .sub_i(sign_a_q ^ sign_b_q),
    .sum_o(alu_sum),
    .co_o (alu_co)
  );

  // FSM: state register
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (in_valid_i) state_d = StUnpack;
      StUnpack: begin
        if (is_special) begin
          state_d = StDone;
        end else if ((udiff == '0) || (udiff >= AlignLimW)) begin
          state_d = StAdd;
        end else begin
          state_d = StAlign;
        end
      end
      StAlign:  if (diff_q == ExpW'(1)) state_d = StAdd;
      StAdd:    state_d = StNorm;
      StNorm:   if (norm_done) state_d = StPack;
      StPack:   state_d = StDone;
      StDone:   if (out_ready_i) state_d = StIdle;
      default:  state_d = StIdle;
    endcase
  end

  // FSM: outputs
  always_comb begin
    in_ready_o  = (state_q == StIdle) && !rst_i;
    out_valid_o = (state_q == StDone);
    busy_o      = (state_q != StIdle);
    result_o    = res_q;
    ovf_o       = ovf_q;
    nan_o       = nan_q;
  end

  // Datapath next state
  always_comb begin
    a_d       = a_q;
    b_d       = b_q;
    sign_a_d  = sign_a_q;
    sign_b_d  = sign_b_q;
    exp_d     = exp_q;
    diff_d    = diff_q;
    mant_a_d  = mant_a_q;
    mant_b_d  = mant_b_q;
    sum_d     = sum_q;
    kind_d    = kind_q;
    res_d     = res_q;
    ovf_d     = ovf_q;
    nan_d     = nan_q;
    norm_done = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (in_valid_i) begin
          a_d = a_i;
          b_d = b_i;
        end
      end
      StUnpack: begin
        if (is_special) begin
          res_d = special_res;
          nan_d = special_nan;
          ovf_d = !special_nan;
        end else begin
          sign_a_d = big_sign;
          sign_b_d = small_sign;
          exp_d    = big_exp;
          diff_d   = udiff;
          kind_d   = KindNum;
          mant_a_d = {big_sig, {GrdBits{1'b0}}};
          // far smaller operand contributes nothing once truncated
          mant_b_d = (udiff >= AlignLimW) ? '0 : {small_sig, {GrdBits{1'b0}}};
        end
      end
      StAlign: begin
        mant_b_d = mant_b_q >> 1;
        diff_d   = diff_q - ExpW'(1);
      end
      StAdd: begin
        sum_d = {alu_co, alu_sum};
      end
      StNorm: begin
        if (sum_q[SumW-1]) begin
          sum_d     = sum_q >> 1;
          exp_d     = exp_q + ExpW'(1);
          norm_done = 1'b1;
          if (exp_q == ExpOnes - ExpW'(1)) kind_d = KindInf;
        end else if (sum_q == '0) begin
          sign_a_d  = 1'b0;  // exact cancellation gives +0
          kind_d    = KindZero;
          norm_done = 1'b1;
        end else if (!sum_q[SumW-2]) begin
          sum_d = sum_q << 1;
          exp_d = exp_q - ExpW'(1);
          if (exp_q == ExpW'(1)) begin
            kind_d    = KindZero;
            norm_done = 1'b1;
          end
        end else begin
          norm_done = 1'b1;
        end
      end
      StPack: begin
        nan_d = 1'b0;
        ovf_d = 1'b0;
        unique case (kind_q)
          KindZero: res_d = {sign_a_q, 31'b0};
          KindInf: begin
            res_d = {sign_a_q, ExpOnes, {FracW{1'b0}}};
            ovf_d = 1'b1;
          end
          default:  res_d = {sign_a_q, exp_q, sum_q[GrdBits +: FracW]};
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      a_q      <= '0;
      b_q      <= '0;
      sign_a_q <= 1'b0;
      sign_b_q <= 1'b0;
      exp_q    <= '0;
      diff_q   <= '0;
      mant_a_q <= '0;
      mant_b_q <= '0;
      sum_q    <= '0;
      kind_q   <= KindNum;
      res_q    <= '0;
      ovf_q    <= 1'b0;
      nan_q    <= 1'b0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      sign_a_q <= sign_a_d;
      sign_b_q <= sign_b_d;
      exp_q    <= exp_d;
      diff_q   <= diff_d;
      mant_a_q <= mant_a_d;
      mant_b_q <= mant_b_d;
      sum_q    <= sum_d;
      kind_q   <= kind_d;
      res_q    <= res_d;
      ovf_q    <= ovf_d;
      nan_q    <= nan_d;
    end
  end

endmodule

// File: doc/add32f_seq_ctrl.md
Name: add32f_seq_ctrl

Overview:
- Multi-cycle sequencer for the 32-bit float adder: accepts an operand pair over a valid/ready handshake.
- Steps one shared datapath through unpack, align, add, normalize and pack, then returns the result over a valid/ready handshake.
- Alignment and normalization are iterative: one bit per cycle, so area stays minimal.
- Sits between the Add32F top level and the IEEE754 field/shift helpers.

Parameters:
- ALIGN_LIMIT, 25: exponent difference at or above which the smaller operand is zeroed in one cycle instead of being shifted.
- GRD_BITS, 3: guard bits carried below the 24-bit significand during align/add; discarded at pack (round toward zero).

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  controller can accept operands.
- a  in  32  operand A, IEEE754 single.
- b  in  32  operand B, IEEE754 single.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts the result.
- result  out  32  IEEE754 single sum.
- ovf  out  1  result overflowed to ±Inf; valid with out_valid.
- nan  out  1  result is NaN; valid with out_valid.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset (rst=1 at an edge, in any state, including mid-operation): state=IDLE, result=0, ovf=0, nan=0, out_valid=0, busy=0. in_ready=1 in the cycle after reset releases. Any in-flight operation is discarded.
- States: IDLE, UNPACK, ALIGN, ADD, NORM, PACK, DONE.
- IDLE: in_ready=1. On in_valid&in_ready, a and b are registered → UNPACK. No other state accepts operands.
- UNPACK (1 cycle):
  - Split sign/exp/frac. exp==0 operands are treated as zero (subnormals flushed).
  - If either exp==255 → DONE with the special result:
    - any NaN, or +Inf plus −Inf → 0x7FC00000, nan=1;
    - otherwise the Inf operand (sign kept), ovf=1.
  - Otherwise swap so A has the larger exponent (ties: larger fraction) and load diff=expA−expB.
    - diff==0 → ADD.
    - diff>=ALIGN_LIMIT → zero B's significand, → ADD.
    - else → ALIGN.
- ALIGN: B significand shifts right 1 bit per cycle; bits shifted past the guard field are dropped; diff decrements. → ADD when diff reaches 0. Takes exactly diff cycles.
- ADD (1 cycle): signs equal → sum of magnitudes; signs differ → A−B (never negative after the swap). Result sign = sign of A. 28-bit sum (carry + 24 + GRD_BITS).
- NORM, one step per cycle:
  - carry set → shift right 1, exp+1, done.
  - sum==0 → result +0, done.
  - MSB (hidden-bit position) clear → shift left 1, exp−1; repeat.
  - MSB set → done.
  - Always at least 1 cycle.
  - exp reaches 0 while shifting left → result signed zero, done.
  - exp reaches 255 → ±Inf, ovf=1.
  - Done → PACK.
- PACK (1 cycle): truncate guard bits and assemble {sign, exp[7:0], frac[22:0]} → DONE.
- DONE: out_valid=1 with result/ovf/nan held stable. On out_ready → IDLE; out_valid drops on that edge. With out_ready held high, DONE lasts 1 cycle.
- Latency from the accepting edge to out_valid=1: 4 + align_cycles + norm_cycles edges, where special cases take 2. Throughput: one operation at a time.
- in_valid in a non-IDLE state is ignored; the source must hold it.

Decomposition:
- Shared `include header, guarded, holding:
  - state encodings (3-bit);
  - FP32 constants: EXP_BIAS=127, EXP_MAX=255, QNAN=32'h7FC00000, POS_INF=32'h7F800000;
  - field widths.
- One natural sub-module: add32f_mant_alu, a combinational 28-bit add/subtract with carry-out, instanced in ADD.
- Shifting and the FSM stay in the controller.

Test Plan:
- 0x3F800000 + 0x3F800000 (1.0+1.0) → 0x40000000; align 0, norm 1 (carry), out_valid 5 edges after accept.
- 0x3F800000 + 0x40000000 (1.0+2.0) → 0x40400000; exactly 1 ALIGN cycle observed.
- 0x3F800000 + 0xBF800000 (1.0−1.0) → 0x00000000; 0x40400000 + 0xC0000000 (3−2) → 0x3F800000, 1 left-shift norm.
- 0x7F7FFFFF + 0x7F7FFFFF → 0x7F800000, ovf=1. 0x7F800000 + 0xFF800000 → 0x7FC00000, nan=1, latency 2.
- 0x4B800000 + 0x3F800000 (2^24+1, diff=24, below ALIGN_LIMIT) → 0x4B800000: 1.0 is fully shifted out over 24 ALIGN cycles and the remaining guard bits are truncated at PACK.
- Hold out_ready=0 for 3 cycles → result stable, in_ready=0; then assert rst during ALIGN → next cycle out_valid=0, busy=0, in_ready=1.
